exmple_md_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one exmple_md-style accumulate datapath (registered result = inpdata + insdata, one-cycle latency) among NREQ requesters.
- Accepts one operation at a time, drives the datapath operands, captures the registered result and returns it with the winner's ID over a valid/ready response channel.
- Sits between requester logic and a single datapath instance.

---
 rtl/exmple_md_arb.sv | 124 ++++++++++++
 tb/tb_exmple_md_arb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exmple_md_arb.sv
// exmple_md_arb: round-robin arbiter sequencing NREQ requesters onto one inpdata+insdata datapath.
// Optional statistics ports (op_cnt, grant_last) are enabled by EXMPLE_MD_ARB_STAT_EN.
module exmple_md_arb #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_vld,
    output logic [NREQ-1:0]     req_rdy,
    input  logic [NREQ*8-1:0]   req_inpdata,
    input  logic [NREQ-1:0]     req_insdata,
    output logic [7:0]          dp_inpdata,
    output logic                dp_insdata,
    input  logic [DSIZE-1:0]    dp_ldata,
    output logic                rsp_vld,
    input  logic                rsp_rdy,
    output logic [IDW-1:0]      rsp_id,
    output logic [DSIZE-1:0]    rsp_data,
`ifdef EXMPLE_MD_ARB_STAT_EN
    output logic [15:0]         op_cnt,
    output logic [IDW-1:0]      grant_last,
`endif
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, rsp_id_q, win;
    logic [7:0]       dp_inpdata_q, sel_data;
    logic             dp_insdata_q, sel_ins, any, accept;
    logic [DSIZE-1:0] rsp_data_q;
    logic [IDW:0]     sum, idx;

    // Descending offset scan so the requester closest to the pointer wins last and therefore sticks.
    always_comb begin
        win = '0;
        sum = '0;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(i);
            idx = (sum >= (IDW+1)'(NREQ)) ? sum - (IDW+1)'(NREQ) : sum;
            if (req_vld[idx[IDW-1:0]]) win = idx[IDW-1:0];
        end
    end

    always_comb begin
        sel_data = '0;
        sel_ins  = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (win == IDW'(j)) begin
                sel_data = req_inpdata[8*j +: 8];
                sel_ins  = req_insdata[j];
            end
        end
    end

    assign any    = |req_vld;
    assign accept = (state_q == IDLE) && any;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = any ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = rsp_rdy ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_rdy = accept ? (NREQ'(1) << win) : '0;
        rsp_vld = (state_q == RESP);
        busy    = (state_q != IDLE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            dp_inpdata_q <= '0;
            dp_insdata_q <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            if (accept) begin
                dp_inpdata_q <= sel_data;
                dp_insdata_q <= sel_ins;
                rsp_id_q     <= win;
                ptr_q        <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
            if (state_q == WAIT) rsp_data_q <= dp_ldata;
        end
    end

    assign dp_inpdata = dp_inpdata_q;
    assign dp_insdata = dp_insdata_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

`ifdef EXMPLE_MD_ARB_STAT_EN
    logic [15:0]    op_cnt_q;
    logic [IDW-1:0] grant_last_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q     <= '0;
            grant_last_q <= '0;
        end else begin
            if (rsp_vld && rsp_rdy && op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 1'b1;
            if (accept) grant_last_q <= win;
        end
    end

    assign op_cnt     = op_cnt_q;
    assign grant_last = grant_last_q;
`endif
endmodule

// File: tb/tb_exmple_md_arb.sv
// tb_exmple_md_arb: directed bench for exmple_md_arb with a behavioural one-cycle accumulate datapath.
module tb_exmple_md_arb;
    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_vld = '0;
    logic [3:0]  req_rdy, req_rdy9;
    logic [31:0] req_inpdata = '0;
    logic [3:0]  req_insdata = '0;
    logic [7:0]  dp_inpdata, dp_inpdata9;
    logic        dp_insdata, dp_insdata9;
    logic [7:0]  dp_ldata;
    logic [8:0]  dp_ldata9;
    logic        rsp_vld, rsp_vld9;
    logic        rsp_rdy = 1'b1;
    logic [1:0]  rsp_id, rsp_id9;
    logic [7:0]  rsp_data;
    logic [8:0]  rsp_data9;
    logic        busy, busy9;
    int          errors = 0;
    int          checks = 0;
`ifdef EXMPLE_MD_ARB_STAT_EN
    logic [15:0] op_cnt, op_cnt9;
    logic [1:0]  grant_last, grant_last9;
`endif

    always #5 clock = ~clock;

    exmple_md_arb #(.NREQ(4), .DSIZE(8)) u8 (
        .clock(clock), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_inpdata(req_inpdata), .req_insdata(req_insdata),
        .dp_inpdata(dp_inpdata), .dp_insdata(dp_insdata), .dp_ldata(dp_ldata),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_data(rsp_data),
`ifdef EXMPLE_MD_ARB_STAT_EN
        .op_cnt(op_cnt), .grant_last(grant_last),
`endif
        .busy(busy));

    exmple_md_arb #(.NREQ(4), .DSIZE(9)) u9 (
        .clock(clock), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy9),
        .req_inpdata(req_inpdata), .req_insdata(req_insdata),
        .dp_inpdata(dp_inpdata9), .dp_insdata(dp_insdata9), .dp_ldata(dp_ldata9),
        .rsp_vld(rsp_vld9), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id9), .rsp_data(rsp_data9),
`ifdef EXMPLE_MD_ARB_STAT_EN
        .op_cnt(op_cnt9), .grant_last(grant_last9),
`endif
        .busy(busy9));

    // Stand-in datapaths: registered inpdata + insdata truncated to DSIZE.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            dp_ldata  <= '0;
            dp_ldata9 <= '0;
        end else begin
            dp_ldata  <= dp_inpdata + 8'(dp_insdata);
            dp_ldata9 <= {1'b0, dp_inpdata9} + 9'(dp_insdata9);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic s);
        req_inpdata[8*i +: 8] = d;
        req_insdata[i] = s;
    endtask

    task automatic test_reset;
        step(2);
        checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld got=%b exp=0", rsp_vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL reset_req_rdy got=%b exp=0000", req_rdy); end
        checks++; if ({dp_inpdata, dp_insdata, rsp_id, rsp_data} !== '0) begin errors++; $display("FAIL reset_regs got=%h/%b/%0d/%h exp=0", dp_inpdata, dp_insdata, rsp_id, rsp_data); end
        rst_n = 1'b1;
        step(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_fairness;
        int exp_id [5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_d [5] = '{8'h10, 8'h21, 8'h20, 8'h31, 8'h10};
        set_req(0, 8'h10, 1'b0); set_req(1, 8'h20, 1'b1);
        set_req(2, 8'h20, 1'b0); set_req(3, 8'h30, 1'b1);
        rsp_rdy = 1'b1;
        req_vld = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_rdy !== 4'(1 << exp_id[k])) begin errors++; $display("FAIL fair_grant%0d got=%b exp=%b", k, req_rdy, 4'(1 << exp_id[k])); end
            step(1);
            if (k == 4) req_vld = 4'b0000;
            checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL fair_issue_rdy%0d got=%b exp=0000", k, req_rdy); end
            step(2);
            checks++; if (rsp_vld !== 1'b1 || rsp_id !== 2'(exp_id[k]) || rsp_data !== exp_d[k]) begin
                errors++; $display("FAIL fair_rsp%0d got=%b/%0d/%h exp=1/%0d/%h", k, rsp_vld, rsp_id, rsp_data, exp_id[k], exp_d[k]);
            end
            step(1);
        end
    endtask

    task automatic test_single;
        set_req(2, 8'h12, 1'b1);
        req_vld = 4'b0100;
        #1;
        checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", req_rdy); end
        step(1);
        req_vld = 4'b0000;
        checks++; if (dp_inpdata !== 8'h12 || dp_insdata !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_issue got=%h/%b/%b exp=12/1/1", dp_inpdata, dp_insdata, busy); end
        step(1);
        checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL single_wait_vld got=%b exp=0", rsp_vld); end
        step(1);
        checks++; if (rsp_vld !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'h13) begin errors++; $display("FAIL single_rsp got=%b/%0d/%h exp=1/2/13", rsp_vld, rsp_id, rsp_data); end
`ifdef EXMPLE_MD_ARB_STAT_EN
        checks++; if (grant_last !== 2'd2) begin errors++; $display("FAIL single_grant_last got=%0d exp=2", grant_last); end
`endif
        step(1);
        checks++; if (rsp_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got=%b/%b exp=0/0", rsp_vld, busy); end
    endtask

    task automatic test_wrap;
        set_req(0, 8'h01, 1'b0);
        set_req(3, 8'hFF, 1'b1);
        req_vld = 4'b1001;
        #1;
        checks++; if (req_rdy !== 4'b1000) begin errors++; $display("FAIL wrap_ptr_grant got=%b exp=1000", req_rdy); end
        step(1);
        req_vld = 4'b0000;
        step(2);
        checks++; if (rsp_vld !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'h00) begin errors++; $display("FAIL wrap_d8 got=%b/%0d/%h exp=1/3/00", rsp_vld, rsp_id, rsp_data); end
        checks++; if (rsp_vld9 !== 1'b1 || rsp_data9 !== 9'h100) begin errors++; $display("FAIL wrap_d9 got=%b/%h exp=1/100", rsp_vld9, rsp_data9); end
        step(1);
    endtask

    task automatic test_backpressure;
        set_req(0, 8'h05, 1'b0);
        req_vld = 4'b0001;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got=%b exp=0001", req_rdy); end
        step(1);
        set_req(1, 8'h07, 1'b1);
        req_vld = 4'b0010;
        rsp_rdy = 1'b0;
        step(2);
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++; if (rsp_vld !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h05 || req_rdy !== 4'b0) begin
                errors++; $display("FAIL bp_hold%0d got=%b/%0d/%h/%b exp=1/0/05/0000", k, rsp_vld, rsp_id, rsp_data, req_rdy);
            end
            step(1);
        end
        rsp_rdy = 1'b1;
        step(1);
        #1;
        checks++; if (rsp_vld !== 1'b0 || req_rdy !== 4'b0010) begin errors++; $display("FAIL bp_release got=%b/%b exp=0/0010", rsp_vld, req_rdy); end
        step(1);
        req_vld = 4'b0000;
        step(2);
        checks++; if (rsp_vld !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h08) begin errors++; $display("FAIL bp_rsp1 got=%b/%0d/%h exp=1/1/08", rsp_vld, rsp_id, rsp_data); end
        step(1);
    endtask

    task automatic test_reset_midop;
        set_req(2, 8'h33, 1'b0);
        req_vld = 4'b0100;
        step(1);
        req_vld = 4'b0000;
        step(1);
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_vld !== 1'b0 || busy !== 1'b0 || req_rdy !== 4'b0) begin errors++; $display("FAIL rst_mid_ctl got=%b/%b/%b exp=0/0/0000", rsp_vld, busy, req_rdy); end
        checks++; if ({dp_inpdata, dp_insdata, rsp_id, rsp_data} !== '0) begin errors++; $display("FAIL rst_mid_regs got=%h/%b/%0d/%h exp=0", dp_inpdata, dp_insdata, rsp_id, rsp_data); end
        step(2);
        rst_n = 1'b1;
        step(1);
        checks++; if (rsp_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_discard got=%b/%b exp=0/0", rsp_vld, busy); end
        set_req(1, 8'h44, 1'b1);
        set_req(3, 8'h50, 1'b0);
        req_vld = 4'b1010;
        #1;
        checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL rst_mid_ptr got=%b exp=0010", req_rdy); end
        step(1);
        req_vld = 4'b0000;
        step(2);
        checks++; if (rsp_vld !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h45) begin errors++; $display("FAIL rst_mid_after got=%b/%0d/%h exp=1/1/45", rsp_vld, rsp_id, rsp_data); end
        step(1);
    endtask

    initial begin
        test_reset;
        test_fairness;
        test_single;
        test_wrap;
        test_backpressure;
        test_reset_midop;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
